// File: rtl/mem_common_pkg.sv
// Shared memory-side packet types and cache-line helpers, plus the IC fill-buffer
// server's line-store types and FSM encoding.
package mem_common;

  localparam int ADDR_W         = 32;
  localparam int CL_BYTES       = 16;
  localparam int CL_BITS        = CL_BYTES * 8;
  localparam int CL_LSB         = $clog2(CL_BYTES);
  localparam int MEM_ID_W       = 4;
  localparam int FE_FB_NUM_ENTS = 4;

  typedef logic [ADDR_W-1:0]   t_addr;
  typedef logic [MEM_ID_W-1:0] t_mem_id;

  typedef union packed {
    logic [CL_BITS-1:0]           flat;
    logic [CL_BYTES/4-1:0][31:0]  word;
  } t_cl;

  typedef struct packed {
    logic    valid;
    t_addr   addr;
    t_mem_id id;
  } t_mem_req_pkt;

  typedef struct packed {
    logic    valid;
    t_mem_id id;
    t_cl     data;
  } t_mem_rsp_pkt;

  function automatic t_addr get_cl_addr(input t_addr a);
    return {a[ADDR_W-1:CL_LSB], {CL_LSB{1'b0}}};
  endfunction

  function automatic logic cl_match(input t_addr a, input t_addr b);
    return get_cl_addr(a) == get_cl_addr(b);
  endfunction

  localparam int IC_NUM_SETS = 64;
  localparam int IC_SET_LSB  = CL_LSB;
  localparam int IC_SET_MSB  = IC_SET_LSB + $clog2(IC_NUM_SETS) - 1;
  localparam int IC_TAG_W    = ADDR_W - IC_SET_MSB - 1;

  typedef logic [IC_SET_MSB-IC_SET_LSB:0] t_ic_setid;
  typedef logic [IC_TAG_W-1:0]            t_ic_tag;

  typedef struct packed {
    logic    valid;
    t_ic_tag tag;
    t_cl     data;
  } t_ic_line;

  typedef struct packed {
    t_addr   addr;
    t_mem_id id;
  } t_ic_req_ent;

  typedef enum logic [2:0] {
    IC_SRV_IDLE,
    IC_SRV_LOOKUP,
    IC_SRV_FILL_REQ,
    IC_SRV_FILL_WAIT,
    IC_SRV_RESP
  } t_ic_srv_state;

endpackage

// File: rtl/ic_fb_server_req_fifo.sv
// Circular request queue between the fill buffer and the IC server FSM.
// Latency: push visible at head the cycle after; head read combinationally.
// Backpressure: none upstream; push at full is only legal with a same-cycle pop.
module ic_req_fifo
  import mem_common::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  t_ic_req_ent push_dat,
  input  logic        pop,
  output t_ic_req_ent head,
  output logic        empty,
  output logic        full
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_ptr, rd_ptr;
  t_ic_req_ent  store [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = store[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr[PW-1:0]] <= push_dat;
        wr_ptr                <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  a_req_ovf: assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop));

endmodule

// File: rtl/ic_fb_server.sv
// Direct-mapped instruction line server for the FE fill buffer; misses fill from memory in order.
// Latency: hit N+3, miss N+3 plus memory handshake/latency. Backpressure: only from mem_ic_rdy_nnn.
// The FB never stalls; every request is queued and responses are single-cycle pulses.
module ic_fb_server
  import mem_common::*;
#(
  parameter int      NUM_SETS  = IC_NUM_SETS,
  parameter int      REQ_DEPTH = 8,
  parameter t_mem_id FILL_ID   = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  t_mem_req_pkt fb_ic_req_nnn,
  output t_mem_rsp_pkt ic_fb_rsp_nnn,
  output t_mem_req_pkt ic_mem_req_nnn,
  input  logic         mem_ic_rdy_nnn,
  input  t_mem_rsp_pkt mem_ic_rsp_nnn
);

  t_ic_srv_state state, state_nxt;
  t_ic_req_ent   head;
  logic          q_empty, q_full, pop;
  t_addr         srv_addr;
  t_mem_id       srv_id;
  t_ic_line      lines [NUM_SETS];
  t_ic_line      cur_line;
  t_ic_setid     srv_set;
  t_ic_tag       srv_tag;
  logic          hit, install, rsp_load, rsp_from_mem;

  ic_req_fifo #(.DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fb_ic_req_nnn.valid),
    .push_dat ('{addr: fb_ic_req_nnn.addr, id: fb_ic_req_nnn.id}),
    .pop      (pop),
    .head     (head),
    .empty    (q_empty),
    .full     (q_full)
  );

  assign srv_set  = srv_addr[IC_SET_MSB:IC_SET_LSB];
  assign srv_tag  = srv_addr[ADDR_W-1:IC_SET_MSB+1];
  assign cur_line = lines[srv_set];
  // Rebuild the resident line's address so the shared cl_match helper decides the hit.
  assign hit      = cur_line.valid &&
                    cl_match({cur_line.tag, srv_set, {IC_SET_LSB{1'b0}}}, srv_addr);

  always_comb begin
    ic_mem_req_nnn       = '0;
    ic_mem_req_nnn.valid = (state == IC_SRV_FILL_REQ);
    ic_mem_req_nnn.addr  = get_cl_addr(srv_addr);
    ic_mem_req_nnn.id    = FILL_ID;
  end

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    install      = 1'b0;
    rsp_load     = 1'b0;
    rsp_from_mem = 1'b0;
    case (state)
      IC_SRV_IDLE: begin
        if (!q_empty) begin
          pop       = 1'b1;
          state_nxt = IC_SRV_LOOKUP;
        end
      end
      IC_SRV_LOOKUP: begin
        if (hit) begin
          rsp_load  = 1'b1;
          state_nxt = IC_SRV_RESP;
        end else begin
          state_nxt = IC_SRV_FILL_REQ;
        end
      end
      IC_SRV_FILL_REQ: begin
        if (mem_ic_rdy_nnn) state_nxt = IC_SRV_FILL_WAIT;
      end
      IC_SRV_FILL_WAIT: begin
        if (mem_ic_rsp_nnn.valid && (mem_ic_rsp_nnn.id == FILL_ID)) begin
          install      = 1'b1;
          rsp_load     = 1'b1;
          rsp_from_mem = 1'b1;
          state_nxt    = IC_SRV_RESP;
        end
      end
      IC_SRV_RESP: begin
        // Response is on the wire this cycle; overlap the next pop to reach one hit per 2 cycles.
        if (!q_empty) begin
          pop       = 1'b1;
          state_nxt = IC_SRV_LOOKUP;
        end else begin
          state_nxt = IC_SRV_IDLE;
        end
      end
      default: state_nxt = IC_SRV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IC_SRV_IDLE;
      srv_addr <= '0;
      srv_id   <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        srv_addr <= head.addr;
        srv_id   <= head.id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SETS; i++) lines[i].valid <= 1'b0;
    end else if (install) begin
      lines[srv_set] <= '{valid: 1'b1, tag: srv_tag, data: mem_ic_rsp_nnn.data};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ic_fb_rsp_nnn <= '0;
    end else begin
      ic_fb_rsp_nnn.valid <= rsp_load;
      if (rsp_load) begin
        ic_fb_rsp_nnn.id   <= srv_id;
        ic_fb_rsp_nnn.data <= rsp_from_mem ? mem_ic_rsp_nnn.data : cur_line.data;
      end
    end
  end

endmodule

// File: tb/tb_ic_fb_server.sv
// Scoreboard bench for ic_fb_server: directed requests, modelled memory, decoupled response checking.
module tb_ic_fb_server;
  import mem_common::*;

  localparam int MEM_LAT = 5;

  typedef struct {
    t_mem_id            id;
    logic [CL_BITS-1:0] data;
    int                 cyc;
  } exp_t;

  logic         clk;
  logic         reset;
  t_mem_req_pkt fb_ic_req_nnn;
  t_mem_rsp_pkt ic_fb_rsp_nnn;
  t_mem_req_pkt ic_mem_req_nnn;
  logic         mem_ic_rdy_nnn;
  t_mem_rsp_pkt mem_ic_rsp_nnn;

  int    cyc = 0;
  int    n_chk = 0;
  int    n_pass = 0;
  int    acc_cnt = 0;
  int    rsp_cd = 0;
  bit    stray_en = 0;
  t_addr rsp_addr;
  exp_t  exp_q[$];
  t_addr exp_mem[$];

  ic_fb_server dut (
    .clk            (clk),
    .reset          (reset),
    .fb_ic_req_nnn  (fb_ic_req_nnn),
    .ic_fb_rsp_nnn  (ic_fb_rsp_nnn),
    .ic_mem_req_nnn (ic_mem_req_nnn),
    .mem_ic_rdy_nnn (mem_ic_rdy_nnn),
    .mem_ic_rsp_nnn (mem_ic_rsp_nnn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [CL_BITS-1:0] line_data(input t_addr a);
    t_addr c = get_cl_addr(a);
    return {c ^ 32'hA5A5_0003, c ^ 32'h5A5A_0002, c + 32'h1111_0001, ~c};
  endfunction

  task automatic chk(input bit ok, input string name, input logic [CL_BITS-1:0] act,
                     input logic [CL_BITS-1:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // FB response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ic_fb_rsp_nnn.valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "fb_rsp_unexpected", CL_BITS'(ic_fb_rsp_nnn.id), '0);
        end else begin
          e = exp_q.pop_front();
          chk(ic_fb_rsp_nnn.id == e.id, "fb_rsp_id", CL_BITS'(ic_fb_rsp_nnn.id), CL_BITS'(e.id));
          chk(ic_fb_rsp_nnn.data.flat == e.data, "fb_rsp_data", ic_fb_rsp_nnn.data.flat, e.data);
          if (e.cyc >= 0) chk(cyc == e.cyc, "fb_rsp_cycle", CL_BITS'(cyc), CL_BITS'(e.cyc));
        end
      end
    end
  end

  // Memory model: checks fill requests on acceptance and answers MEM_LAT cycles later
  initial begin
    t_addr a;
    mem_ic_rsp_nnn = '0;
    forever begin
      @(negedge clk);
      mem_ic_rsp_nnn = '0;
      if (rsp_cd > 0) begin
        rsp_cd--;
        if (rsp_cd == 2 && stray_en) begin
          mem_ic_rsp_nnn.valid     = 1'b1;
          mem_ic_rsp_nnn.id        = 4'd5;
          mem_ic_rsp_nnn.data.flat = {4{32'hDEAD_BEEF}};
        end
        if (rsp_cd == 0) begin
          mem_ic_rsp_nnn.valid     = 1'b1;
          mem_ic_rsp_nnn.id        = 4'd0;
          mem_ic_rsp_nnn.data.flat = line_data(rsp_addr);
        end
      end
      if (ic_mem_req_nnn.valid && mem_ic_rdy_nnn) begin
        acc_cnt++;
        chk(ic_mem_req_nnn.id == 4'd0, "mem_req_id", CL_BITS'(ic_mem_req_nnn.id), '0);
        if (exp_mem.size() == 0) begin
          chk(1'b0, "mem_req_unexpected", CL_BITS'(ic_mem_req_nnn.addr), '0);
        end else begin
          a = exp_mem.pop_front();
          chk(ic_mem_req_nnn.addr == a, "mem_req_addr", CL_BITS'(ic_mem_req_nnn.addr), CL_BITS'(a));
        end
        rsp_addr = ic_mem_req_nnn.addr;
        rsp_cd   = MEM_LAT;
      end
    end
  end

  task automatic send(input t_addr a, input t_mem_id id, input bit expect_rsp,
                      input logic [CL_BITS-1:0] data, input int lat);
    exp_t e;
    @(negedge clk);
    fb_ic_req_nnn = '{valid: 1'b1, addr: a, id: id};
    if (expect_rsp) begin
      e.id   = id;
      e.data = data;
      e.cyc  = (lat < 0) ? -1 : cyc + lat;
      exp_q.push_back(e);
    end
  endtask

  task automatic req_idle();
    @(negedge clk);
    fb_ic_req_nnn = '0;
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || exp_mem.size() != 0 || rsp_cd != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(n < max_cyc, name, CL_BITS'(exp_q.size() + exp_mem.size()), '0);
  endtask

  initial begin
    t_addr a, b;
    int    acc0;
    int    n;

    reset          = 1'b0;
    mem_ic_rdy_nnn = 1'b1;
    fb_ic_req_nnn  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(ic_fb_rsp_nnn.valid == 1'b0, "reset_fb_rsp_valid", CL_BITS'(ic_fb_rsp_nnn.valid), '0);
    chk(ic_mem_req_nnn.valid == 1'b0, "reset_mem_req_valid", CL_BITS'(ic_mem_req_nnn.valid), '0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: cold miss
    exp_mem.push_back(32'h1000);
    send(32'h1000, 4'd3, 1'b1, line_data(32'h1000), -1);
    req_idle();
    wait_drain(100, "t1_cold_miss_drain");

    // 2: warm hit in the same line, exact N+3
    send(32'h1004, 4'd1, 1'b1, line_data(32'h1000), 3);
    req_idle();
    wait_drain(100, "t2_warm_hit_drain");

    // 3: make sets 1..8 resident, then a back-to-back burst of hits
    for (int k = 0; k < 8; k++) begin
      a = 32'h2000 + t_addr'((k + 1) * 16);
      exp_mem.push_back(a);
      send(a, 4'd15, 1'b1, line_data(a), -1);
      req_idle();
      wait_drain(100, "t3_prefill_drain");
    end
    for (int k = 0; k < 8; k++) begin
      a = 32'h2000 + t_addr'((k + 1) * 16);
      send(a, t_mem_id'(k), 1'b1, line_data(a), 3 + k);
    end
    req_idle();
    wait_drain(200, "t3_burst_drain");

    // 4: memory holds off ready for 10 cycles; a stray-id response is also injected
    mem_ic_rdy_nnn = 1'b0;
    acc0 = acc_cnt;
    exp_mem.push_back(32'h3090);
    send(32'h3090, 4'd2, 1'b1, line_data(32'h3090), -1);
    req_idle();
    n = 0;
    while (!ic_mem_req_nnn.valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(n < 20, "t4_mem_req_seen", CL_BITS'(n), '0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk(ic_mem_req_nnn.valid && ic_mem_req_nnn.addr == 32'h3090, "t4_mem_req_stable",
          CL_BITS'(ic_mem_req_nnn.addr), CL_BITS'(32'h3090));
    end
    @(posedge clk);
    #1;
    stray_en       = 1'b1;
    mem_ic_rdy_nnn = 1'b1;
    wait_drain(100, "t4_backpressure_drain");
    chk(acc_cnt - acc0 == 1, "t4_accept_count", CL_BITS'(acc_cnt - acc0), CL_BITS'(1));

    // 5: reset during the fill wait; the late memory response must be dropped
    acc0 = acc_cnt;
    exp_mem.push_back(32'h40A0);
    send(32'h40A0, 4'd4, 1'b0, '0, -1);
    req_idle();
    n = 0;
    while (acc_cnt == acc0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(n < 20, "t5_fill_accepted", CL_BITS'(n), '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk(ic_fb_rsp_nnn.valid == 1'b0, "t5_reset_fb_rsp", CL_BITS'(ic_fb_rsp_nnn.valid), '0);
    chk(ic_mem_req_nnn.valid == 1'b0, "t5_reset_mem_req", CL_BITS'(ic_mem_req_nnn.valid), '0);
    repeat (10) @(negedge clk);
    exp_mem.push_back(32'h40A0);
    send(32'h40A0, 4'd5, 1'b1, line_data(32'h40A0), -1);
    req_idle();
    wait_drain(100, "t5_refill_drain");

    // 6: same-set conflict, strict ordering and eviction
    a = 32'h50B0;
    b = 32'h60B0;
    exp_mem.push_back(a);
    exp_mem.push_back(b);
    send(a, 4'd6, 1'b1, line_data(a), -1);
    send(b, 4'd7, 1'b1, line_data(b), -1);
    req_idle();
    wait_drain(200, "t6_conflict_drain");
    exp_mem.push_back(a);
    send(a, 4'd8, 1'b1, line_data(a), -1);
    req_idle();
    wait_drain(100, "t6_refill_a_drain");
    exp_mem.push_back(b);
    send(b, 4'd9, 1'b1, line_data(b), -1);
    req_idle();
    wait_drain(100, "t6_refill_b_drain");

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
